// File: rtl/balotelli_bus_pkg.sv
// rtl/balotelli_bus_pkg.sv - shared types and helpers for the Balotelli data-memory bridge
// Contents:
//   dmem_state_t       bridge FSM states
//   ERR_RDATA_DEFAULT  read data returned to the core when a read times out
//   sel_w()            byte-lane count for a given data width
package balotelli_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUS      = 2'd1,
    ST_RESP     = 2'd2,
    ST_WAIT_LOW = 2'd3
  } dmem_state_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  function automatic int sel_w(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/balotelli_dmem_wb_bridge_if.sv
// rtl/balotelli_dmem_wb_bridge_if.sv - Wishbone-classic data port between bridge and memory
// Signals (named from the bridge's point of view):
//   wb_cyc_o, wb_stb_o  cycle / strobe
//   wb_we_o             write enable
//   wb_addr_o           address            [ADDR_WIDTH]
//   wb_sel_o            byte select        [DATA_WIDTH/8]
//   wb_dat_o            write data         [DATA_WIDTH]
//   wb_dat_i            read data          [DATA_WIDTH]
//   wb_ack_i            acknowledge
// Modports: master (bridge), slave (memory side / bench responder).
interface balotelli_dmem_wb_bridge_if
  import balotelli_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  localparam int SEL_W = sel_w(DATA_WIDTH);

  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_addr_o;
  logic [SEL_W-1:0]      wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - counts stalled bus cycles and flags the final allowed one
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          count this cycle (strobe high, no ack)
//   clr         restart from zero (transaction start)
//   expired     this is cycle TIMEOUT_CYCLES of the stall; abort at the coming edge
// TIMEOUT_CYCLES = 0 disables expiry.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // count_q holds the number of stalled cycles already completed, so the
  // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES > 0) && (count_q == LAST);

endmodule

// File: rtl/balotelli_dmem_wb_bridge.sv
// rtl/balotelli_dmem_wb_bridge.sv - Balotelli core data port to registered Wishbone-classic master
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus_request_i   level request from the core, held until the completion pulse
//   raddr_i/waddr_i read / write address
//   wdata_i         write data
//   wmask_i         byte write mask; nonzero = write, zero = read
//   rdata_o         read data, held until the next read completes
//   read_ready_o    one-cycle read completion pulse
//   write_over_o    one-cycle write completion pulse
//   err_o           sticky timeout flag, cleared by err_clr_i (a new timeout wins)
//   err_clr_i       synchronous clear of err_o
//   wb              Wishbone master port (balotelli_dmem_wb_bridge_if.master)
module balotelli_dmem_wb_bridge
  import balotelli_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 1023,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(ERR_RDATA_DEFAULT)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           bus_request_i,
  input  logic [ADDR_WIDTH-1:0]          raddr_i,
  input  logic [ADDR_WIDTH-1:0]          waddr_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [sel_w(DATA_WIDTH)-1:0]   wmask_i,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           read_ready_o,
  output logic                           write_over_o,
  output logic                           err_o,
  input  logic                           err_clr_i,
  balotelli_dmem_wb_bridge_if.master     wb
);

  localparam int SEL_W = sel_w(DATA_WIDTH);

  dmem_state_t           state_q, state_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [SEL_W-1:0]      sel_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  cyc_q;
  logic                  err_q;
  logic                  rearm_q;

  logic start;
  logic in_bus;
  logic done_ack;
  logic done_to;
  logic expired;
  logic is_write;

  assign is_write = |wmask_i;
  // rearm_q is cleared when a transaction starts and set again only once the
  // core has dropped its request, so a held level can never start a second one.
  assign start    = (state_q == ST_IDLE) && bus_request_i && rearm_q;
  assign in_bus   = (state_q == ST_BUS);
  // Ack has priority over an expiring timeout in the same cycle.
  assign done_ack = in_bus && wb.wb_ack_i;
  assign done_to  = in_bus && !wb.wb_ack_i && expired;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (in_bus && !wb.wb_ack_i),
    .clr     (start),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_BUS;
      ST_BUS:      if (done_ack || done_to) state_d = ST_RESP;
      ST_RESP:     state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!bus_request_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read_ready_o = 1'b0;
    write_over_o = 1'b0;
    if (state_q == ST_RESP) begin
      read_ready_o = !we_q;
      write_over_o = we_q;
    end
  end

  // Request latch, Wishbone strobe and response registers. cyc_q mirrors the
  // BUS state but is its own flop so the bus pins never see decode logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cyc_q   <= 1'b0;
      err_q   <= 1'b0;
      rearm_q <= 1'b1;
    end else begin
      if (start) begin
        we_q    <= is_write;
        addr_q  <= is_write ? waddr_i : raddr_i;
        sel_q   <= is_write ? wmask_i : '1;
        wdata_q <= wdata_i;
        cyc_q   <= 1'b1;
      end else if (done_ack || done_to) begin
        cyc_q   <= 1'b0;
      end

      if (done_ack && !we_q) begin
        rdata_q <= wb.wb_dat_i;
      end else if (done_to && !we_q) begin
        rdata_q <= ERR_RDATA;
      end

      if (done_to) begin
        err_q <= 1'b1;
      end else if (err_clr_i) begin
        err_q <= 1'b0;
      end

      if (start) begin
        rearm_q <= 1'b0;
      end else if (!bus_request_i) begin
        rearm_q <= 1'b1;
      end
    end
  end

  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = cyc_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_sel_o  = sel_q;
  assign wb.wb_dat_o  = wdata_q;
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_balotelli_dmem_wb_bridge.sv
// tb/tb_balotelli_dmem_wb_bridge.sv - scoreboard bench for balotelli_dmem_wb_bridge
module tb_balotelli_dmem_wb_bridge;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] raddr = '0;
  logic [31:0] waddr = '0;
  logic [31:0] wdata_r = '0;
  logic [3:0]  wmask_r = '0;
  logic [31:0] rdata_o;
  logic        read_ready_o;
  logic        write_over_o;
  logic        err_o;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  exp_t        q[$];
  exp_t        mon_e;
  exp_t        e6;
  logic [31:0] model_rdata = '0;
  logic        err_model = 1'b0;

  int          s_delay = 0;
  bit          s_ack_on = 1'b0;
  logic [31:0] s_dat = '0;
  int          s_cnt = 0;
  logic        prev_stb = 1'b0;
  int          stb_run = 0;
  int          txn_count = 0;

  logic        r_we;
  logic [3:0]  r_mask;
  logic [31:0] r_addr;

  balotelli_dmem_wb_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  balotelli_dmem_wb_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_request_i (req),
    .raddr_i       (raddr),
    .waddr_i       (waddr),
    .wdata_i       (wdata_r),
    .wmask_i       (wmask_r),
    .rdata_o       (rdata_o),
    .read_ready_o  (read_ready_o),
    .write_over_o  (write_over_o),
    .err_o         (err_o),
    .err_clr_i     (err_clr),
    .wb            (wb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor, scoreboard pop and Wishbone responder, all sampled on the falling edge.
  always @(negedge clk) begin
    if (read_ready_o || write_over_o) begin
      check_eq("pulse_excl", 64'(read_ready_o & write_over_o), 64'd0);
      check_eq("sb_nonempty", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        check_eq("pulse_kind", 64'(write_over_o), 64'(mon_e.we));
        check_eq("rdata", 64'(rdata_o), 64'(mon_e.rdata));
        check_eq("err", 64'(err_o), 64'(mon_e.err));
      end
    end
    if (wb.wb_stb_o) begin
      if (!prev_stb) begin
        txn_count++;
        stb_run = 1;
      end else begin
        stb_run++;
      end
      check_eq("cyc_eq_stb", 64'(wb.wb_cyc_o), 64'd1);
      check_eq("stb_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) begin
        check_eq("wb_addr", 64'(wb.wb_addr_o), 64'(q[0].addr));
        check_eq("wb_we", 64'(wb.wb_we_o), 64'(q[0].we));
        check_eq("wb_sel", 64'(wb.wb_sel_o), 64'(q[0].sel));
        if (q[0].we) check_eq("wb_dat_o", 64'(wb.wb_dat_o), 64'(q[0].wdata));
      end
    end
    if (wb.wb_stb_o && s_ack_on) begin
      if (s_cnt == s_delay) begin
        wb.wb_ack_i = 1'b1;
        wb.wb_dat_i = s_dat;
      end else begin
        wb.wb_ack_i = 1'b0;
        wb.wb_dat_i = $urandom;
      end
      s_cnt++;
    end else begin
      wb.wb_ack_i = 1'b0;
      wb.wb_dat_i = $urandom;
      s_cnt = 0;
    end
    prev_stb = wb.wb_stb_o;
  end

  // One core transaction: push the expectation, raise the request, wait for
  // the pulse, check latency and strobe length, then hold and drop the request.
  task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask, input int delay,
                        input bit ack_on, input logic [31:0] dat, input int hold, input int clr_at);
    exp_t e;
    int   n;
    int   c0;
    bit   done;
    bit   to;
    to = !ack_on || (delay >= 8);
    e.we = we;
    e.addr = addr;
    e.sel = we ? wmask : 4'hF;
    e.wdata = wdata;
    if (!we) model_rdata = to ? 32'hDEAD_BEEF : dat;
    e.rdata = model_rdata;
    if (to) err_model = 1'b1;
    e.err = err_model;
    s_delay = delay;
    s_ack_on = ack_on;
    s_dat = dat;
    @(posedge clk);
    #1;
    q.push_back(e);
    raddr = we ? $urandom : addr;
    waddr = we ? addr : $urandom;
    wdata_r = wdata;
    wmask_r = we ? wmask : 4'h0;
    req = 1'b1;
    c0 = txn_count;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (read_ready_o || write_over_o) begin
        done = 1'b1;
      end else begin
        err_clr = (n == clr_at);
        if (n >= 1) begin
          raddr = $urandom;
          waddr = $urandom;
          wdata_r = $urandom;
          wmask_r = 4'($urandom);
        end
        n++;
      end
    end
    err_clr = 1'b0;
    check_eq({name, "_done"}, 64'(done), 64'd1);
    check_eq({name, "_latency"}, 64'(n), 64'(to ? 9 : delay + 2));
    check_eq({name, "_stb_cycles"}, 64'(stb_run), 64'(to ? 8 : delay + 1));
    repeat (hold) @(posedge clk);
    check_eq({name, "_txn_count"}, 64'(txn_count - c0), 64'd1);
    @(posedge clk);
    #1;
    req = 1'b0;
    if (!done) q.delete();
  endtask

  task automatic clear_err();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    err_model = 1'b0;
    @(negedge clk);
    check_eq("err_cleared", 64'(err_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_cyc", 64'(wb.wb_cyc_o), 64'd0);
    check_eq("rst_stb", 64'(wb.wb_stb_o), 64'd0);
    check_eq("rst_we", 64'(wb.wb_we_o), 64'd0);
    check_eq("rst_addr", 64'(wb.wb_addr_o), 64'd0);
    check_eq("rst_sel", 64'(wb.wb_sel_o), 64'd0);
    check_eq("rst_dat_o", 64'(wb.wb_dat_o), 64'd0);
    check_eq("rst_rdata", 64'(rdata_o), 64'd0);
    check_eq("rst_pulses", 64'({read_ready_o, write_over_o}), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    rst_n = 1'b1;

    do_txn("s1_read", 1'b0, 32'h100, 32'h0, 4'h0, 3, 1'b1, 32'hCAFE_F00D, 0, -1);
    do_txn("s2_write", 1'b1, 32'h204, 32'h1122_3344, 4'b0110, 0, 1'b1, 32'h0, 0, -1);
    do_txn("s3_held", 1'b0, 32'h040, 32'h0, 4'h0, 1, 1'b1, 32'h0BAD_CAFE, 10, -1);
    do_txn("s3_again", 1'b1, 32'h044, 32'hA5A5_A5A5, 4'b1001, 2, 1'b1, 32'h0, 0, -1);

    for (int i = 0; i < 6; i++) begin
      r_we = 1'($urandom_range(0, 1));
      r_mask = r_we ? 4'($urandom_range(1, 15)) : 4'h0;
      r_addr = $urandom & 32'h0000_FFFC;
      do_txn("rand", r_we, r_addr, $urandom, r_mask, int'($urandom_range(0, 5)), 1'b1,
             $urandom, 0, -1);
    end

    do_txn("s4_timeout", 1'b0, 32'h300, 32'h0, 4'h0, 0, 1'b0, 32'h0, 0, -1);
    repeat (3) @(negedge clk);
    check_eq("s4_err_sticky", 64'(err_o), 64'd1);
    clear_err();

    // err_clr_i is high exactly at the edge where the timeout fires.
    do_txn("s4_clr_race", 1'b1, 32'h308, 32'h0000_0055, 4'h1, 0, 1'b0, 32'h0, 0, 8);
    check_eq("s4_clr_race_rdata_held", 64'(rdata_o), 64'(model_rdata));
    clear_err();

    do_txn("s5_ack_at_expiry", 1'b0, 32'h310, 32'h0, 4'h0, 7, 1'b1, 32'h1234_5678, 0, -1);
    check_eq("s5_err_clear", 64'(err_o), 64'd0);

    @(posedge clk);
    #1;
    s_ack_on = 1'b0;
    e6.we = 1'b0;
    e6.addr = 32'h3F0;
    e6.sel = 4'hF;
    e6.wdata = 32'h0;
    e6.rdata = 32'h0;
    e6.err = 1'b0;
    q.push_back(e6);
    raddr = 32'h3F0;
    wmask_r = 4'h0;
    req = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("s6_stb_before_rst", 64'(wb.wb_stb_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("s6_cyc_async", 64'(wb.wb_cyc_o), 64'd0);
    check_eq("s6_stb_async", 64'(wb.wb_stb_o), 64'd0);
    q.delete();
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("s6_no_pulse", 64'({read_ready_o, write_over_o}), 64'd0);
    end
    check_eq("s6_rst_rdata", 64'(rdata_o), 64'd0);
    rst_n = 1'b1;
    model_rdata = '0;
    err_model = 1'b0;
    do_txn("s6_after", 1'b0, 32'h100, 32'h0, 4'h0, 3, 1'b1, 32'hCAFE_F00D, 0, -1);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
